mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
- Multi-cycle multiply/divide sequencer beside the single-cycle ALU.
- Executes MIPS R-type mult/multu/div/divu iteratively with one shared 33-bit add/sub step, and owns the HI/LO registers.
- Issues a start/busy/done handshake so the pipeline control can stall on mfhi/mflo or a new MDU op while an operation is in flight.
- Also performs single-cycle mthi/mtlo writes.

Parameters:
- DATA_W, 32, operand and HI/LO width; iteration count equals DATA_W.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  request; sampled only in IDLE.
- funct_i  in  6  R-type funct field, sampled with start_i.
- src1_i  in  DATA_W  rs value (multiplicand/dividend; mthi/mtlo data).
- src2_i  in  DATA_W  rt value (multiplier/divisor).
- busy_o  out  1  operation in flight; the pipeline stalls MDU-dependent instructions while high.
- done_o  out  1  one-cycle pulse; HI/LO are valid this cycle.
- hi_o  out  DATA_W  HI register (product high half / remainder).
- lo_o  out  DATA_W  LO register (product low half / quotient).

Behaviour:
- Reset (rst_i low, async): state=IDLE; busy_o=0; done_o=0; hi_o=0; lo_o=0; counter=0; operand registers=0.
- Funct codes: mult 011000, multu 011001, div 011010, divu 011011, mthi 010001, mtlo 010011. start_i with any other funct is ignored: no state change, no busy.
- FSM states are IDLE, CALC, FIX, DONE.
- IDLE:
  - start_i with mthi/mtlo: write src1_i to HI or LO at that edge; stay IDLE; no busy, no done.
  - start_i with mult/div: latch operands, converting signed ops to magnitudes and recording result sign(s); counter=DATA_W-1; go to CALC; busy_o=1 from the next cycle.
- CALC (DATA_W cycles):
  - Multiply: shift-add, one multiplier bit per cycle.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - Counter decrements; at 0 go to FIX.
- FIX (1 cycle):
  - Signed mult: negate the 2*DATA_W product if the operand signs differ.
  - Signed div: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write HI/LO; go to DONE.
- DONE (1 cycle): done_o=1, busy_o=0; return to IDLE.
- A new start_i is accepted in the DONE cycle (back-to-back); the next op is busy from the following cycle.
- Latency: start edge at cycle 0 gives done_o high in cycle DATA_W+2 (34 for the default). busy_o is high cycles 1..DATA_W+1.
- hi_o/lo_o keep their old values during CALC and update only at the FIX->DONE edge.
- start_i while busy_o=1 is ignored. The controller must not assert it; the bench checks that the state is unaffected.
- Divide by zero (divisor==0 at latch, signed or unsigned):
  - Full latency is kept.
  - lo_o = all ones; hi_o = the original src1_i value (unmodified).
- Signed overflow div (-2^(DATA_W-1) / -1): lo_o = 0x80000000, hi_o = 0. No trap.
- Reset mid-operation: immediate return to IDLE and all outputs cleared; no done pulse is produced.
- All arithmetic is modular at its stated width. The internal accumulator is DATA_W+1 bits so the subtract borrow is visible.

Decomposition:
- Package mdu_pkg holds:
  - the funct constants (F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO);
  - the state enum (S_IDLE, S_CALC, S_FIX, S_DONE);
  - DATA_W default.
- One sub-module, mdu_step: purely combinational single-iteration datapath (add-or-pass for multiply, subtract-and-restore for divide). mdu_seq holds the FSM, counter, sign handling and HI/LO.

Test Plan:
- multu 0xFFFFFFFF x 0xFFFFFFFF -> done_o exactly at cycle 34; hi_o=0xFFFFFFFE, lo_o=0x00000001; busy_o high cycles 1-33.
- mult -3 (0xFFFFFFFD) x 5 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1. Then back-to-back div -7 / 2 started in the DONE cycle -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- divu 7 / 0 -> lo_o=0xFFFFFFFF, hi_o=0x00000007 at cycle 34. div 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 in consecutive cycles -> hi_o/lo_o update the cycle after each edge; busy_o and done_o stay 0.
- During divu 100/7, hold start_i high with funct=mult for 10 cycles -> ignored; result lo_o=14, hi_o=2. Unknown funct 100001 with start_i in IDLE -> no busy.
- Drop rst_i low at cycle 15 of a mult -> busy_o, hi_o, lo_o go to 0 asynchronously; no done_o. After release, a new multu 3 x 4 -> lo_o=12, hi_o=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared constants and types for the multiply/divide sequencer.
package mdu_pkg;
  localparam int DATA_W = 32;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
endpackage

// File: rtl/mdu_seq_if.sv
// Request/result bundle between pipeline control (master) and the MDU (slave).
interface mdu_seq_if #(parameter int DATA_W = 32);
  logic              start_i;
  logic [5:0]        funct_i;
  logic [DATA_W-1:0] src1_i;
  logic [DATA_W-1:0] src2_i;
  logic              busy_o;
  logic              done_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (output start_i, funct_i, src1_i, src2_i,
                  input  busy_o, done_o, hi_o, lo_o);
  modport slave  (input  start_i, funct_i, src1_i, src2_i,
                  output busy_o, done_o, hi_o, lo_o);
endinterface

// File: rtl/mdu_step.sv
// One iteration of shift-add multiply or restoring divide; purely combinational.
// The add/sub is DATA_W+1 bits wide so the multiply carry and divide borrow land in the top bit.
module mdu_step #(parameter int DATA_W = 32) (
  input  logic              i_div,
  input  logic [DATA_W-1:0] i_acc,
  input  logic [DATA_W-1:0] i_q,
  input  logic [DATA_W-1:0] i_op,
  output logic [DATA_W-1:0] o_acc,
  output logic [DATA_W-1:0] o_q
);
  logic [DATA_W-1:0] w_addend;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_shl;
  logic [DATA_W:0]   w_diff;

  assign w_addend = i_q[0] ? i_op : {DATA_W{1'b0}};
  assign w_sum    = {1'b0, i_acc} + {1'b0, w_addend};
  assign w_shl    = {i_acc, i_q[DATA_W-1]};
  assign w_diff   = w_shl - {1'b0, i_op};

  always_comb begin
    o_acc = w_sum[DATA_W:1];
    o_q   = {w_sum[0], i_q[DATA_W-1:1]};
    if (i_div) begin
      // Borrow set means the trial subtract went negative: keep the shifted remainder.
      if (w_diff[DATA_W]) begin
        o_acc = w_shl[DATA_W-1:0];
        o_q   = {i_q[DATA_W-2:0], 1'b0};
      end else begin
        o_acc = w_diff[DATA_W-1:0];
        o_q   = {i_q[DATA_W-2:0], 1'b1};
      end
    end
  end
endmodule

// File: rtl/mdu_seq.sv
// Iterative MIPS mult/div sequencer that owns HI/LO; done_o pulses DATA_W+2 cycles after start.
// start_i is only honoured in IDLE or DONE; mthi/mtlo complete at the accepting edge.
module mdu_seq #(parameter int DATA_W = mdu_pkg::DATA_W) (
  input  logic     clk_i,
  input  logic     rst_i,
  mdu_seq_if.slave bus
);
  import mdu_pkg::*;

  localparam int CNT_W = $clog2(DATA_W);

  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_acc, r_q, r_op, r_hi, r_lo;
  logic                r_is_div, r_neg_q, r_neg_r, r_div0;

  logic                w_accept, w_md, w_signed, w_neg1, w_neg2, w_busy, w_done;
  logic [DATA_W-1:0]   w_mag1, w_mag2, w_acc_nxt, w_q_nxt, w_quo, w_rem;
  logic [2*DATA_W-1:0] w_prod;

  assign w_accept = bus.start_i && (r_state == S_IDLE || r_state == S_DONE);
  assign w_md     = bus.funct_i inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
  assign w_signed = (bus.funct_i == F_MULT) || (bus.funct_i == F_DIV);
  assign w_neg1   = w_signed && bus.src1_i[DATA_W-1];
  assign w_neg2   = w_signed && bus.src2_i[DATA_W-1];
  assign w_mag1   = w_neg1 ? -bus.src1_i : bus.src1_i;
  assign w_mag2   = w_neg2 ? -bus.src2_i : bus.src2_i;

  // Sign fix-up; divide-by-zero forces all-ones quotient, remainder sign fix restores src1.
  assign w_prod = r_neg_q ? -{r_acc, r_q} : {r_acc, r_q};
  assign w_quo  = r_div0 ? {DATA_W{1'b1}} : (r_neg_q ? -r_q : r_q);
  assign w_rem  = r_neg_r ? -r_acc : r_acc;

  mdu_step #(.DATA_W(DATA_W)) u_step (
    .i_div (r_is_div),
    .i_acc (r_acc),
    .i_q   (r_q),
    .i_op  (r_op),
    .o_acc (w_acc_nxt),
    .o_q   (w_q_nxt)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_done = (r_state == S_DONE);
        w_next = (w_accept && w_md) ? S_CALC : S_IDLE;
      end
      S_CALC: begin
        w_busy = 1'b1;
        if (r_cnt == '0) w_next = S_FIX;
      end
      S_FIX: begin
        w_busy = 1'b1;
        w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_op     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
    end else if (w_accept) begin
      if (bus.funct_i == F_MTHI) r_hi <= bus.src1_i;
      if (bus.funct_i == F_MTLO) r_lo <= bus.src1_i;
      if (w_md) begin
        r_is_div <= bus.funct_i[1];
        r_neg_q  <= w_neg1 ^ w_neg2;
        r_neg_r  <= w_neg1;
        r_div0   <= bus.funct_i[1] && (bus.src2_i == '0);
        r_cnt    <= CNT_W'(DATA_W - 1);
        r_acc    <= '0;
        // Divide shifts the dividend out of r_q; multiply shifts the multiplier out.
        r_q      <= bus.funct_i[1] ? w_mag1 : w_mag2;
        r_op     <= bus.funct_i[1] ? w_mag2 : w_mag1;
      end
    end else if (r_state == S_CALC) begin
      r_acc <= w_acc_nxt;
      r_q   <= w_q_nxt;
      r_cnt <= r_cnt - CNT_W'(1);
    end else if (r_state == S_FIX) begin
      if (r_is_div) begin
        r_hi <= w_rem;
        r_lo <= w_quo;
      end else begin
        r_hi <= w_prod[2*DATA_W-1:DATA_W];
        r_lo <= w_prod[DATA_W-1:0];
      end
    end
  end

  assign bus.busy_o = w_busy;
  assign bus.done_o = w_done;
  assign bus.hi_o   = r_hi;
  assign bus.lo_o   = r_lo;
endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: fixed vectors, corner sequences and a random run vs. an arithmetic model.
module tb_mdu_seq;
  import mdu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi, m_lo;

  mdu_seq_if #(.DATA_W(32)) bus ();
  mdu_seq #(.DATA_W(32)) dut (.clk_i(clk_i), .rst_i(rst_n), .bus(bus));

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] a, b, hi, lo;
    bit          b2b;
    int          noise;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int     sa, sb;
    longint p;
    sa = a;
    sb = b;
    case (f)
      F_MULT: begin
        p = longint'(sa) * longint'(sb);
        return p;
      end
      F_MULTU: return {32'd0, a} * {32'd0, b};
      F_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Called at a negedge with the DUT idle or in DONE; returns at the negedge of the DONE cycle.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int noise);
    int done_cyc = -1;
    int busy_err = 0;
    bus.start_i = 1'b1;
    bus.funct_i = f;
    bus.src1_i  = a;
    bus.src2_i  = b;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (bus.done_o === 1'b1) begin
        done_cyc = cyc;
        if (bus.busy_o !== 1'b0) busy_err++;
        break;
      end
      if (bus.busy_o !== (cyc <= 33)) busy_err++;
      if (cyc >= 2 && cyc < 2 + noise) begin
        bus.start_i = 1'b1;
        bus.funct_i = F_MULT;
        bus.src1_i  = $urandom;
        bus.src2_i  = $urandom;
      end else begin
        bus.start_i = 1'b0;
      end
      @(negedge clk_i);
    end
    bus.start_i = 1'b0;
    chk({tag, ".done_cycle"}, 64'(done_cyc), 64'd34);
    chk({tag, ".busy_pattern_errs"}, 64'(busy_err), 64'd0);
    chk({tag, ".hi"}, {32'd0, bus.hi_o}, {32'd0, exp_hi});
    chk({tag, ".lo"}, {32'd0, bus.lo_o}, {32'd0, exp_lo});
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  initial begin
    vec_t        vt[9];
    logic [63:0] r;
    logic [5:0]  f;
    logic [31:0] a, b;
    int          seen;

    vt[0] = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0};
    vt[1] = '{F_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0};
    vt[2] = '{F_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 0};
    vt[3] = '{F_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 1'b0, 0};
    vt[4] = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 0};
    vt[5] = '{F_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, 0};
    vt[6] = '{F_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0, 0};
    vt[7] = '{F_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0, 0};
    vt[8] = '{F_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 10};

    rst_n       = 1'b0;
    bus.start_i = 1'b0;
    bus.funct_i = '0;
    bus.src1_i  = '0;
    bus.src2_i  = '0;
    repeat (2) @(negedge clk_i);
    chk("reset.busy", {63'd0, bus.busy_o}, 64'd0);
    chk("reset.done", {63'd0, bus.done_o}, 64'd0);
    chk("reset.hi", {32'd0, bus.hi_o}, 64'd0);
    chk("reset.lo", {32'd0, bus.lo_o}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 9; i++) begin
      if (!vt[i].b2b) @(negedge clk_i);
      run_op($sformatf("vec%0d", i), vt[i].funct, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, vt[i].noise);
    end

    // mthi then mtlo on consecutive edges
    @(negedge clk_i);
    bus.start_i = 1'b1;
    bus.funct_i = F_MTHI;
    bus.src1_i  = 32'h1234_5678;
    @(negedge clk_i);
    chk("mthi.hi", {32'd0, bus.hi_o}, 64'h1234_5678);
    chk("mthi.busy_done", {62'd0, bus.busy_o, bus.done_o}, 64'd0);
    bus.funct_i = F_MTLO;
    bus.src1_i  = 32'h9ABC_DEF0;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    chk("mtlo.lo", {32'd0, bus.lo_o}, 64'h9ABC_DEF0);
    chk("mtlo.hi_kept", {32'd0, bus.hi_o}, 64'h1234_5678);
    chk("mtlo.busy_done", {62'd0, bus.busy_o, bus.done_o}, 64'd0);
    m_hi = 32'h1234_5678;
    m_lo = 32'h9ABC_DEF0;

    // Unknown funct is ignored
    bus.start_i = 1'b1;
    bus.funct_i = 6'b100001;
    bus.src1_i  = 32'hDEAD_BEEF;
    bus.src2_i  = 32'd1;
    seen = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) seen++;
    end
    bus.start_i = 1'b0;
    chk("badfunct.busy_done_seen", 64'(seen), 64'd0);
    chk("badfunct.hi", {32'd0, bus.hi_o}, {32'd0, m_hi});
    chk("badfunct.lo", {32'd0, bus.lo_o}, {32'd0, m_lo});

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: f = F_MULT;
        1: f = F_MULTU;
        2: f = F_DIV;
        default: f = F_DIVU;
      endcase
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
      r = model(f, a, b);
      if ($urandom_range(0, 1) == 1) @(negedge clk_i);
      run_op($sformatf("rnd%0d", i), f, a, b, r[63:32], r[31:0], 0);
    end

    // Asynchronous reset in the middle of a multiply
    @(negedge clk_i);
    bus.start_i = 1'b1;
    bus.funct_i = F_MULT;
    bus.src1_i  = 32'h0001_2345;
    bus.src2_i  = 32'hFFFF_0001;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    repeat (14) @(negedge clk_i);
    chk("midrst.busy_before", {63'd0, bus.busy_o}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.busy", {63'd0, bus.busy_o}, 64'd0);
    chk("midrst.hi", {32'd0, bus.hi_o}, 64'd0);
    chk("midrst.lo", {32'd0, bus.lo_o}, 64'd0);
    seen = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (bus.done_o !== 1'b0) seen++;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk_i);
      if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) seen++;
    end
    chk("midrst.no_done_or_busy", 64'(seen), 64'd0);
    run_op("after_rst", F_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
